sdram_rr_arbiter: RTL
=====================

// Module: sdram_rr_arbiter
// PURPOSE
//  Shares the single Avalon bridge master (SoC path to SDRAM controller) among three requesters:
//  SD-card loader (write), video reader (read port 1), audio reader (read port 2).
//  Write port has fixed priority; read ports alternate round-robin. One transaction in flight at a time.
//  A per-transaction watchdog aborts a transfer the bridge never acknowledges and flags the error.
// PARAMETERS
//  ADDR_W   26    byte address width on bridge and requester ports
//  DATA_W   16    data word width
//  TIMEOUT  1024  cycles in BUSY without bridge ack before abort (>=2)
// PORTS
//  clk50          in   1       system clock, 50 MHz
//  reset_n        in   1       asynchronous reset, active low
//  write_override in   1       1 = only write port may be granted; reads stall
//  wr_req         in   1       write request (level, held until wr_ack)
//  wr_addr        in   ADDR_W  write address, stable while wr_req=1
//  wr_data        in   DATA_W  write data, stable while wr_req=1
//  wr_ack         out  1       one-cycle pulse: write complete
//  rd1_req        in   1       read request port 1 (level)
//  rd1_addr       in   ADDR_W  read address port 1
//  rd1_ack        out  1       one-cycle pulse: rd1_data valid
//  rd1_data       out  DATA_W  read data port 1, held until next rd1 completion
//  rd2_req/rd2_addr/rd2_ack/rd2_data  as port 1, for port 2
//  avl_addr       out  ADDR_W  bridge address (registered)
//  avl_read       out  1       bridge read strobe (registered)
//  avl_write      out  1       bridge write strobe (registered)
//  avl_wrdata     out  DATA_W  bridge write data (registered)
//  avl_ack        in   1       bridge acknowledge, single-cycle pulse
//  avl_rddata     in   DATA_W  bridge read data, valid with avl_ack
//  grant          out  2       current owner: 0 none, 1 rd1, 2 rd2, 3 write
//  timeout_err    out  1       sticky: a transaction was aborted by the watchdog
// BEHAVIOUR
//  Reset (reset_n=0, async): all outputs 0, state IDLE, rr pointer = port 1 next, watchdog 0.
//  States: IDLE -> BUSY -> DONE -> IDLE; BUSY -> IDLE on timeout.
//  IDLE: sample requests each edge. Selection, highest first:
//   - wr_req=1 -> write.
//   - write_override=1 -> no read granted, stay IDLE.
//   - rd1_req & rd2_req -> port named by rr pointer; pointer then flips to the other port.
//   - single read request -> that port; pointer set to the other port.
//   On grant: latch addr/data into avl_* regs, assert avl_read or avl_write, set grant, go BUSY.
//   Strobes therefore appear 1 cycle after the request is first seen.
//  BUSY: strobes and address held constant. On avl_ack: drop strobe same edge, capture avl_rddata
//   into rdN_data (reads only), pulse the owner's *_ack for exactly one cycle, go DONE.
//  DONE: one cycle; no new grant (lets requester drop req or update addr); grant->0; go IDLE.
//  Minimum transaction spacing: 3 cycles (IDLE, BUSY with immediate ack, DONE).
//  Watchdog: counts cycles in BUSY; cleared on entering BUSY. Count reaching TIMEOUT-1 without
//   avl_ack: drop strobe, grant->0, set timeout_err, go IDLE, no *_ack pulse. Request stays
//   pending and is re-arbitrated normally (retry).
//  avl_ack while IDLE/DONE is ignored. avl_ack on the same edge as the timeout wins (completes normally).
//  write_override rising during a read in BUSY: read completes; override only affects next grant.
//  Requester dropping req mid-BUSY: transaction still completes and acks; data written to rdN_data.
//  Async reset mid-transaction: strobes drop immediately; no ack generated; timeout_err cleared.
//  rdN_data changes only on that port's completion edge; never on other ports' traffic.
// TESTING
//  1 Reset, rd1_req=1 addr 0x100, bridge acks 4 cycles after strobe with 0xBEEF -> avl_read 1 cycle
//    after req, avl_addr=0x100, rd1_ack single pulse, rd1_data=0xBEEF, grant returns 0.
//  2 rd1_req and rd2_req held high, ack after 1 cycle -> grants alternate 1,2,1,2 for 8 transactions;
//    each port 4 acks; gap between strobes = 3 cycles.
//  3 wr_req with rd1/rd2 pending, write_override=0 -> write granted first (avl_write, wrdata=wr_data),
//    then reads round-robin; with override=1 -> only writes served, reads never strobe.
//  4 Bridge never acks, TIMEOUT=16 -> strobe drops after 16 BUSY cycles, timeout_err=1, no rd1_ack,
//    request retried; then ack 0x1234 -> rd1_ack pulse, timeout_err stays 1.
//  5 Assert reset_n=0 during BUSY -> avl_read/avl_write/grant/timeout_err 0 asynchronously; after
//    release, pending rd2_req granted cleanly, rr pointer starts at port 1.
//  6 Spurious avl_ack in IDLE -> no *_ack pulse, rdN_data unchanged.

Source files
------------

// File: rtl/sdram_rr_arbiter_if.sv
// Requester ports, Avalon bridge master and status bundle for sdram_rr_arbiter.
// "master" is the arbiter's view; "slave" is the requester/bridge view.
interface sdram_rr_arbiter_if #(
   parameter int ADDR_W = 26,
   parameter int DATA_W = 16
);
   logic              write_override;
   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ack;
   logic              rd1_req;
   logic [ADDR_W-1:0] rd1_addr;
   logic              rd1_ack;
   logic [DATA_W-1:0] rd1_data;
   logic              rd2_req;
   logic [ADDR_W-1:0] rd2_addr;
   logic              rd2_ack;
   logic [DATA_W-1:0] rd2_data;
   logic [ADDR_W-1:0] avl_addr;
   logic              avl_read;
   logic              avl_write;
   logic [DATA_W-1:0] avl_wrdata;
   logic              avl_ack;
   logic [DATA_W-1:0] avl_rddata;
   logic [1:0]        grant;
   logic              timeout_err;

   modport master (
      input  write_override,
      input  wr_req, wr_addr, wr_data,
      output wr_ack,
      input  rd1_req, rd1_addr,
      output rd1_ack, rd1_data,
      input  rd2_req, rd2_addr,
      output rd2_ack, rd2_data,
      output avl_addr, avl_read, avl_write, avl_wrdata,
      input  avl_ack, avl_rddata,
      output grant, timeout_err
   );

   modport slave (
      output write_override,
      output wr_req, wr_addr, wr_data,
      input  wr_ack,
      output rd1_req, rd1_addr,
      input  rd1_ack, rd1_data,
      output rd2_req, rd2_addr,
      input  rd2_ack, rd2_data,
      input  avl_addr, avl_read, avl_write, avl_wrdata,
      output avl_ack, avl_rddata,
      input  grant, timeout_err
   );
endinterface

// File: rtl/sdram_rr_arbiter.sv
// Shares one Avalon bridge master among a write port and two read ports.
// Write wins, reads alternate; a watchdog aborts transfers never acknowledged.
module sdram_rr_arbiter #(
   parameter int ADDR_W  = 26,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 1024
) (
   input logic                clk50,
   input logic                reset_n,
   sdram_rr_arbiter_if.master bus
);
   localparam int WD_W = $clog2(TIMEOUT);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   localparam logic [1:0] G_NONE = 2'd0;
   localparam logic [1:0] G_RD1  = 2'd1;
   localparam logic [1:0] G_RD2  = 2'd2;
   localparam logic [1:0] G_WR   = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              rr_q, rr_d;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic [ADDR_W-1:0] avl_addr_q, avl_addr_d;
   logic [DATA_W-1:0] avl_wrdata_q, avl_wrdata_d;
   logic              avl_read_q, avl_read_d;
   logic              avl_write_q, avl_write_d;
   logic [1:0]        grant_q, grant_d;
   logic              err_q, err_d;
   logic              wr_ack_q, wr_ack_d;
   logic              rd1_ack_q, rd1_ack_d;
   logic              rd2_ack_q, rd2_ack_d;
   logic [DATA_W-1:0] rd1_data_q, rd1_data_d;
   logic [DATA_W-1:0] rd2_data_q, rd2_data_d;
   logic              pick_rd1;
   logic              pick_rd2;

   // rr_q = 0 means port 1 wins the next tie
   assign pick_rd1 = bus.rd1_req & (~bus.rd2_req | ~rr_q);
   assign pick_rd2 = bus.rd2_req & (~bus.rd1_req |  rr_q);

   always_comb begin
      state_d      = state_q;
      rr_d         = rr_q;
      wd_d         = wd_q;
      avl_addr_d   = avl_addr_q;
      avl_wrdata_d = avl_wrdata_q;
      avl_read_d   = avl_read_q;
      avl_write_d  = avl_write_q;
      grant_d      = grant_q;
      err_d        = err_q;
      wr_ack_d     = 1'b0;
      rd1_ack_d    = 1'b0;
      rd2_ack_d    = 1'b0;
      rd1_data_d   = rd1_data_q;
      rd2_data_d   = rd2_data_q;
      unique case (state_q)
         S_IDLE: begin
            wd_d = '0;
            if (bus.wr_req) begin
               avl_addr_d   = bus.wr_addr;
               avl_wrdata_d = bus.wr_data;
               avl_write_d  = 1'b1;
               grant_d      = G_WR;
               state_d      = S_BUSY;
            end else if (!bus.write_override && pick_rd1) begin
               avl_addr_d = bus.rd1_addr;
               avl_read_d = 1'b1;
               grant_d    = G_RD1;
               rr_d       = 1'b1;
               state_d    = S_BUSY;
            end else if (!bus.write_override && pick_rd2) begin
               avl_addr_d = bus.rd2_addr;
               avl_read_d = 1'b1;
               grant_d    = G_RD2;
               rr_d       = 1'b0;
               state_d    = S_BUSY;
            end
         end
         S_BUSY: begin
            if (bus.avl_ack) begin
               avl_read_d  = 1'b0;
               avl_write_d = 1'b0;
               state_d     = S_DONE;
               unique case (grant_q)
                  G_RD1: begin
                     rd1_data_d = bus.avl_rddata;
                     rd1_ack_d  = 1'b1;
                  end
                  G_RD2: begin
                     rd2_data_d = bus.avl_rddata;
                     rd2_ack_d  = 1'b1;
                  end
                  G_WR:    wr_ack_d = 1'b1;
                  default: ;
               endcase
            end else if (wd_q == WD_LAST) begin
               // abort without ack; the request stays pending and retries
               avl_read_d  = 1'b0;
               avl_write_d = 1'b0;
               grant_d     = G_NONE;
               err_d       = 1'b1;
               state_d     = S_IDLE;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         S_DONE: begin
            grant_d = G_NONE;
            state_d = S_IDLE;
         end
         default: begin
            avl_read_d  = 1'b0;
            avl_write_d = 1'b0;
            grant_d     = G_NONE;
            state_d     = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         rr_q         <= 1'b0;
         wd_q         <= '0;
         avl_addr_q   <= '0;
         avl_wrdata_q <= '0;
         avl_read_q   <= 1'b0;
         avl_write_q  <= 1'b0;
         grant_q      <= G_NONE;
         err_q        <= 1'b0;
         wr_ack_q     <= 1'b0;
         rd1_ack_q    <= 1'b0;
         rd2_ack_q    <= 1'b0;
         rd1_data_q   <= '0;
         rd2_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         rr_q         <= rr_d;
         wd_q         <= wd_d;
         avl_addr_q   <= avl_addr_d;
         avl_wrdata_q <= avl_wrdata_d;
         avl_read_q   <= avl_read_d;
         avl_write_q  <= avl_write_d;
         grant_q      <= grant_d;
         err_q        <= err_d;
         wr_ack_q     <= wr_ack_d;
         rd1_ack_q    <= rd1_ack_d;
         rd2_ack_q    <= rd2_ack_d;
         rd1_data_q   <= rd1_data_d;
         rd2_data_q   <= rd2_data_d;
      end
   end

   assign bus.avl_addr    = avl_addr_q;
   assign bus.avl_wrdata  = avl_wrdata_q;
   assign bus.avl_read    = avl_read_q;
   assign bus.avl_write   = avl_write_q;
   assign bus.grant       = grant_q;
   assign bus.timeout_err = err_q;
   assign bus.wr_ack      = wr_ack_q;
   assign bus.rd1_ack     = rd1_ack_q;
   assign bus.rd2_ack     = rd2_ack_q;
   assign bus.rd1_data    = rd1_data_q;
   assign bus.rd2_data    = rd2_data_q;
endmodule
